// File: rtl/trace_buffer_if.sv
// Retire and read-port bundle for trace_buffer.
// The master side drives retires and read requests; the slave side (the buffer) returns popped entries.
interface trace_buffer_if #(
  parameter int PcWidth    = 32,
  parameter int Lanes      = 1,
  parameter int CycleWidth = 32
);
  logic [Lanes-1:0]         retireValid;
  logic [Lanes*PcWidth-1:0] retirePc;
  logic [31:0]              hostIoValue;
  logic                     readReq;
  logic                     readValid;
  logic [PcWidth-1:0]       readPc;
  logic [CycleWidth-1:0]    readCycle;
  logic [CycleWidth-1:0]    readOpId;

  modport master (
    output retireValid, retirePc, hostIoValue, readReq,
    input  readValid, readPc, readCycle, readOpId
  );

  modport slave (
    input  retireValid, retirePc, hostIoValue, readReq,
    output readValid, readPc, readCycle, readOpId
  );
endinterface

// File: rtl/trace_buffer.sv
// Retired-instruction trace buffer: captures {pc, cycle, opId} per retire into a ring or
// stop-on-full FIFO.
//   state     | meaning
//   IDLE      | after reset, nothing recorded yet
//   RECORDING | retires are captured
//   STOPPED   | retires ignored, stored entries still readable
module trace_buffer #(
  parameter int PcWidth      = 32,
  parameter int Depth        = 64,
  parameter int Lanes        = 1,
  parameter int CycleWidth   = 32,
  parameter bit StopWhenFull = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  trace_buffer_if.slave          bus,
  output logic [1:0]             state,
  output logic [$clog2(Depth):0] count,
  output logic                   overflow
);
  localparam int AddrWidth = $clog2(Depth);
  localparam logic [AddrWidth:0]    FullCount = (AddrWidth + 1)'(Depth);
  localparam logic [AddrWidth:0]    CntOne    = (AddrWidth + 1)'(1);
  localparam logic [AddrWidth-1:0]  PtrOne    = AddrWidth'(1);
  localparam logic [CycleWidth-1:0] OpOne     = CycleWidth'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECORDING = 2'd1,
    STOPPED   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [AddrWidth-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [AddrWidth:0]    cnt_q, cnt_d;
  logic [CycleWidth-1:0] cyc_q, op_q, op_d;
  logic                  ovf_q, ovf_d;
  logic                  pop;

  logic                  lane0_valid, lane1_valid;
  logic [PcWidth-1:0]    lane0_pc, lane1_pc;
  logic                  we0, we1;
  logic [AddrWidth-1:0]  waddr0, waddr1;
  logic [CycleWidth-1:0] wop0, wop1;

  logic [PcWidth-1:0]    mem_pc  [Depth];
  logic [CycleWidth-1:0] mem_cyc [Depth];
  logic [CycleWidth-1:0] mem_op  [Depth];

  assign lane0_valid = bus.retireValid[0];
  assign lane0_pc    = bus.retirePc[PcWidth-1:0];

  if (Lanes > 1) begin : g_lane1
    assign lane1_valid = bus.retireValid[Lanes-1];
    assign lane1_pc    = bus.retirePc[Lanes*PcWidth-1 -: PcWidth];
  end else begin : g_lane1_off
    assign lane1_valid = 1'b0;
    assign lane1_pc    = '0;
  end

  // Pop is applied first, then lane 0, then lane 1; each step sees the previous step's count.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ovf_d   = ovf_q;
    pop     = 1'b0;
    we0     = 1'b0;
    we1     = 1'b0;
    waddr0  = '0;
    waddr1  = '0;
    wop0    = '0;
    wop1    = '0;
    if (start) begin
      state_d = RECORDING;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      op_d    = '0;
      ovf_d   = 1'b0;
    end else begin
      if (bus.readReq && (cnt_q != '0)) begin
        pop   = 1'b1;
        rd_d  = rd_q + PtrOne;
        cnt_d = cnt_q - CntOne;
      end
      if (stop) begin
        state_d = STOPPED;
      end else if (state_q == RECORDING) begin
        if (lane0_valid) begin
          wop0 = op_d;
          op_d = op_d + OpOne;
          if (cnt_d == FullCount) begin
            ovf_d = 1'b1;
            if (StopWhenFull) begin
              state_d = STOPPED;
            end else begin
              we0    = 1'b1;
              waddr0 = wr_d;
              wr_d   = wr_d + PtrOne;
              rd_d   = rd_d + PtrOne;
            end
          end else begin
            we0    = 1'b1;
            waddr0 = wr_d;
            wr_d   = wr_d + PtrOne;
            cnt_d  = cnt_d + CntOne;
            if (StopWhenFull && (cnt_d == FullCount)) state_d = STOPPED;
          end
        end
        if (lane1_valid) begin
          wop1 = op_d;
          op_d = op_d + OpOne;
          if (cnt_d == FullCount) begin
            ovf_d = 1'b1;
            if (StopWhenFull) begin
              state_d = STOPPED;
            end else begin
              we1    = 1'b1;
              waddr1 = wr_d;
              wr_d   = wr_d + PtrOne;
              rd_d   = rd_d + PtrOne;
            end
          end else begin
            we1    = 1'b1;
            waddr1 = wr_d;
            wr_d   = wr_d + PtrOne;
            cnt_d  = cnt_d + CntOne;
            if (StopWhenFull && (cnt_d == FullCount)) state_d = STOPPED;
          end
        end
        if ((lane0_valid || lane1_valid) && (bus.hostIoValue != 32'd0)) state_d = STOPPED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      op_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_q + OpOne;
      op_q    <= op_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is never reset; count gates every read so stale slots are never presented.
  always_ff @(posedge clk) begin
    if (we0) begin
      mem_pc[waddr0]  <= lane0_pc;
      mem_cyc[waddr0] <= cyc_q;
      mem_op[waddr0]  <= wop0;
    end
    if (we1) begin
      mem_pc[waddr1]  <= lane1_pc;
      mem_cyc[waddr1] <= cyc_q;
      mem_op[waddr1]  <= wop1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.readValid <= 1'b0;
      bus.readPc    <= '0;
      bus.readCycle <= '0;
      bus.readOpId  <= '0;
    end else begin
      bus.readValid <= pop;
      if (pop) begin
        bus.readPc    <= mem_pc[rd_q];
        bus.readCycle <= mem_cyc[rd_q];
        bus.readOpId  <= mem_op[rd_q];
      end
    end
  end

  assign state    = state_q;
  assign count    = cnt_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: a ring-mode single-lane instance and a stop-mode dual-lane
// instance, both checked against a queue-based reference model.
module tb_trace_buffer;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] cyc;
    logic [31:0] op;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        start_a, stop_a, start_b, stop_b;
  logic [1:0]  state_a, state_b;
  logic [2:0]  count_a, count_b;
  logic        overflow_a, overflow_b;
  logic [31:0] tb_cyc;

  int tests  = 0;
  int failed = 0;

  entry_t qa[$], qb[$], ra[$], rb[$];
  int          st_a = 0, st_b = 0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        ovf_a = 1'b0, ovf_b = 1'b0;

  trace_buffer_if #(.PcWidth(32), .Lanes(1), .CycleWidth(32)) bus_a ();
  trace_buffer_if #(.PcWidth(32), .Lanes(2), .CycleWidth(32)) bus_b ();

  trace_buffer #(
    .PcWidth(32), .Depth(4), .Lanes(1), .CycleWidth(32), .StopWhenFull(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .bus(bus_a),
    .state(state_a), .count(count_a), .overflow(overflow_a)
  );

  trace_buffer #(
    .PcWidth(32), .Depth(4), .Lanes(2), .CycleWidth(32), .StopWhenFull(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .bus(bus_b),
    .state(state_b), .count(count_b), .overflow(overflow_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) tb_cyc <= '0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    start_a = 1'b0; stop_a = 1'b0; start_b = 1'b0; stop_b = 1'b0;
    bus_a.retireValid = '0; bus_a.retirePc = '0; bus_a.hostIoValue = '0; bus_a.readReq = 1'b0;
    bus_b.retireValid = '0; bus_b.retirePc = '0; bus_b.hostIoValue = '0; bus_b.readReq = 1'b0;
  endtask

  // Model the cycle from the inputs currently driven, advance one clock, then compare.
  task automatic tick();
    entry_t e, dropped;
    if (rst) begin
      qa.delete(); qb.delete(); ra.delete(); rb.delete();
      st_a = 0; st_b = 0; op_a = '0; op_b = '0; ovf_a = 1'b0; ovf_b = 1'b0;
    end else begin
      if (start_a) begin
        qa.delete(); op_a = '0; ovf_a = 1'b0; st_a = 1;
      end else begin
        if (bus_a.readReq && qa.size() > 0) ra.push_back(qa.pop_front());
        if (stop_a) st_a = 2;
        else if (st_a == 1 && bus_a.retireValid != '0) begin
          e.pc = bus_a.retirePc; e.cyc = tb_cyc; e.op = op_a; op_a++;
          if (qa.size() == 4) begin dropped = qa.pop_front(); ovf_a = 1'b1; end
          qa.push_back(e);
          if (bus_a.hostIoValue != 0) st_a = 2;
        end
      end
      if (start_b) begin
        qb.delete(); op_b = '0; ovf_b = 1'b0; st_b = 1;
      end else begin
        if (bus_b.readReq && qb.size() > 0) rb.push_back(qb.pop_front());
        if (stop_b) st_b = 2;
        else if (st_b == 1) begin
          for (int i = 0; i < 2; i++) begin
            if (((bus_b.retireValid >> i) & 2'b01) != 2'b00) begin
              e.pc = 32'(bus_b.retirePc >> (i * 32)); e.cyc = tb_cyc; e.op = op_b; op_b++;
              if (qb.size() == 4) begin ovf_b = 1'b1; st_b = 2; end
              else begin
                qb.push_back(e);
                if (qb.size() == 4) st_b = 2;
              end
            end
          end
          if (bus_b.retireValid != '0 && bus_b.hostIoValue != 0) st_b = 2;
        end
      end
    end
    @(posedge clk);
    #1;
    check("a_state", state_a, st_a);
    check("a_count", count_a, qa.size());
    check("a_overflow", overflow_a, ovf_a);
    if (ra.size() > 0) begin
      e = ra.pop_front();
      check("a_rvalid", bus_a.readValid, 1);
      check("a_rpc", bus_a.readPc, e.pc);
      check("a_rcycle", bus_a.readCycle, e.cyc);
      check("a_ropid", bus_a.readOpId, e.op);
    end else check("a_rvalid_idle", bus_a.readValid, 0);
    check("b_state", state_b, st_b);
    check("b_count", count_b, qb.size());
    check("b_overflow", overflow_b, ovf_b);
    if (rb.size() > 0) begin
      e = rb.pop_front();
      check("b_rvalid", bus_b.readValid, 1);
      check("b_rpc", bus_b.readPc, e.pc);
      check("b_rcycle", bus_b.readCycle, e.cyc);
      check("b_ropid", bus_b.readOpId, e.op);
    end else check("b_rvalid_idle", bus_b.readValid, 0);
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_state", state_a, 0);
    check("rst_count", count_a, 0);
    check("rst_overflow", overflow_a, 0);
    check("rst_rvalid", bus_a.readValid, 0);
    check("rst_rpc", bus_a.readPc, 0);
    check("rst_rcycle", bus_a.readCycle, 0);
    check("rst_ropid", bus_a.readOpId, 0);
    check("rst_b_state", state_b, 0);

    bus_a.readReq = 1'b1; tick();
    check("empty_read_rvalid", bus_a.readValid, 0);

    // ring mode: six retires into four slots
    start_a = 1'b1; tick();
    check("start_state", state_a, 1);
    for (int k = 0; k < 6; k++) begin
      bus_a.retireValid = 1'b1; bus_a.retirePc = 32'h100 + 32'(4 * k); tick();
    end
    check("ring_count", count_a, 4);
    check("ring_overflow", overflow_a, 1);
    for (int k = 0; k < 4; k++) begin
      bus_a.readReq = 1'b1; tick();
      check("ring_read_pc", bus_a.readPc, 32'h108 + 32'(4 * k));
      check("ring_read_opid", bus_a.readOpId, 32'(2 + k));
    end
    check("ring_drained", count_a, 0);
    tick();
    check("hold_pc", bus_a.readPc, 32'h114);
    check("hold_opid", bus_a.readOpId, 32'd5);

    // full ring with simultaneous pop and write
    start_a = 1'b1; tick();
    for (int k = 0; k < 4; k++) begin
      bus_a.retireValid = 1'b1; bus_a.retirePc = 32'h300 + 32'(4 * k); tick();
    end
    bus_a.retireValid = 1'b1; bus_a.retirePc = 32'h310; bus_a.readReq = 1'b1; tick();
    check("popwrite_pc", bus_a.readPc, 32'h300);
    check("popwrite_count", count_a, 4);
    check("popwrite_overflow", overflow_a, 0);
    for (int k = 0; k < 4; k++) begin bus_a.readReq = 1'b1; tick(); end

    // host I/O stop
    bus_a.retireValid = 1'b1; bus_a.retirePc = 32'h200; bus_a.hostIoValue = 32'd1; tick();
    check("host_state", state_a, 2);
    check("host_count", count_a, 1);
    bus_a.retireValid = 1'b1; bus_a.retirePc = 32'h204; tick();
    check("stopped_ignore", count_a, 1);
    bus_a.readReq = 1'b1; tick();
    check("host_read_pc", bus_a.readPc, 32'h200);

    // start+stop together from STOPPED with overflow set
    start_a = 1'b1; tick();
    for (int k = 0; k < 5; k++) begin
      bus_a.retireValid = 1'b1; bus_a.retirePc = 32'h400 + 32'(4 * k); tick();
    end
    stop_a = 1'b1; bus_a.retireValid = 1'b1; bus_a.retirePc = 32'h4f0; tick();
    check("stop_state", state_a, 2);
    start_a = 1'b1; stop_a = 1'b1; bus_a.retireValid = 1'b1; bus_a.retirePc = 32'h4f4; tick();
    check("startstop_state", state_a, 1);
    check("startstop_count", count_a, 0);
    check("startstop_overflow", overflow_a, 0);
    bus_a.retireValid = 1'b1; bus_a.retirePc = 32'h500; tick();
    bus_a.retireValid = 1'b1; bus_a.retirePc = 32'h504; tick();
    stop_a = 1'b1; bus_a.retireValid = 1'b1; bus_a.retirePc = 32'h508; tick();
    check("stop_cycle_nocapture", count_a, 2);
    bus_a.readReq = 1'b1; tick();
    check("post_start_opid", bus_a.readOpId, 0);
    bus_a.readReq = 1'b1; tick();

    // stop mode, dual lanes
    start_b = 1'b1; tick();
    bus_b.retireValid = 2'b11; bus_b.retirePc = {32'h604, 32'h600}; tick();
    check("dual_c1_count", count_b, 2);
    bus_b.retireValid = 2'b11; bus_b.retirePc = {32'h60c, 32'h608}; tick();
    check("dual_c2_state", state_b, 2);
    check("dual_c2_count", count_b, 4);
    bus_b.retireValid = 2'b11; bus_b.retirePc = {32'h614, 32'h610}; tick();
    check("dual_c3_count", count_b, 4);
    check("dual_c3_overflow", overflow_b, 0);
    for (int k = 0; k < 4; k++) begin
      bus_b.readReq = 1'b1; tick();
      check("dual_read_pc", bus_b.readPc, 32'h600 + 32'(4 * k));
    end
    check("dual_last_opid", bus_b.readOpId, 3);

    // stop mode drop of lane 1 when lane 0 fills the buffer
    start_b = 1'b1; tick();
    bus_b.retireValid = 2'b11; bus_b.retirePc = {32'h704, 32'h700}; tick();
    bus_b.retireValid = 2'b01; bus_b.retirePc = {32'h7ff, 32'h708}; tick();
    bus_b.retireValid = 2'b11; bus_b.retirePc = {32'h710, 32'h70c}; tick();
    check("drop_state", state_b, 2);
    check("drop_count", count_b, 4);
    check("drop_overflow", overflow_b, 1);
    for (int k = 0; k < 4; k++) begin bus_b.readReq = 1'b1; tick(); end
    check("drop_last_pc", bus_b.readPc, 32'h70c);

    // reset mid-recording
    start_a = 1'b1; tick();
    for (int k = 0; k < 3; k++) begin
      bus_a.retireValid = 1'b1; bus_a.retirePc = 32'h800 + 32'(4 * k); tick();
    end
    check("pre_rst_count", count_a, 3);
    rst = 1'b1; bus_a.retireValid = 1'b1; bus_a.retirePc = 32'h900; bus_a.readReq = 1'b1; tick();
    rst = 1'b0;
    check("mid_rst_count", count_a, 0);
    check("mid_rst_state", state_a, 0);
    bus_a.readReq = 1'b1; tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter PcWidth, default 32, retired-PC width in bits.
REQ-002 SHALL have parameter Depth, default 64, entry count; a power of two, at least 4.
REQ-003 SHALL have parameter Lanes, default 1, retire lanes per cycle; legal values 1 or 2.
REQ-004 SHALL have parameter CycleWidth, default 32, width of the cycle and opId counters.
REQ-005 SHALL have parameter StopWhenFull, default 0, selecting the full-buffer policy: 0 = ring (overwrite oldest), 1 = stop.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port start, input, 1, a pulse that clears the buffer and begins recording.
REQ-009 SHALL have port stop, input, 1, a pulse that forces the STOPPED state.
REQ-010 SHALL have port retireValid, input, Lanes, per-lane retire strobe; lane 0 is older.
REQ-011 SHALL have port retirePc, input, Lanes*PcWidth, per-lane PC; lane i occupies bits [i*PcWidth +: PcWidth].
REQ-012 SHALL have port hostIoValue, input, 32, the host I/O value; a nonzero value ends recording.
REQ-013 SHALL have port readReq, input, 1, a request to pop the oldest entry.
REQ-014 SHALL have port readValid, output, 1, a one-cycle strobe marking valid read data.
REQ-015 SHALL have ports readPc (PcWidth), readCycle (CycleWidth) and readOpId (CycleWidth), outputs, carrying the popped entry.
REQ-016 SHALL have port state, output, 2, the FSM state: IDLE=0, RECORDING=1, STOPPED=2.
REQ-017 SHALL have port count, output, $clog2(Depth)+1, the number of stored entries.
REQ-018 SHALL have port overflow, output, 1, sticky; set when an entry was overwritten or dropped.

Function
REQ-019 SHALL run a free-running cycle counter: 0 in the first cycle after reset, +1 every cycle, wrapping modulo 2^CycleWidth, including while IDLE or STOPPED.
REQ-020 SHALL define each entry as {pc, cycle, opId}; cycle is the counter value in the cycle of capture.
REQ-021 SHALL count every retire strobe seen while RECORDING with opId, including dropped ones; opId wraps modulo 2^CycleWidth.
REQ-022 SHALL, when two lanes are valid, give lane 0 opId N and lane 1 opId N+1.
REQ-023 SHALL make these FSM transitions:
- IDLE -> RECORDING on start.
- RECORDING -> STOPPED on stop, on a hostIoValue stop (REQ-024), or on full when StopWhenFull=1.
- STOPPED -> RECORDING on start.
REQ-024 SHALL, in a RECORDING cycle with any retireValid and hostIoValue!=0, capture that cycle's retires and then enter STOPPED.
REQ-025 SHALL capture no retires in a stop-pulse cycle and SHALL ignore retires in IDLE and STOPPED.
REQ-026 SHALL, on start, zero count, the pointers, opId and overflow in the same cycle; retires in the start cycle are not captured.
REQ-027 SHALL give start priority over stop when both are asserted in the same cycle.
REQ-028 SHALL apply same-cycle ordering: pop first, then lane 0 write, then lane 1 write.
REQ-029 SHALL, in ring mode with count==Depth, overwrite the oldest entry on a write, advance the read pointer, hold count and set overflow.
REQ-030 SHALL, in stop mode, drop any write arriving at count==Depth, set overflow and enter STOPPED.
REQ-031 SHALL, in stop mode, enter STOPPED in the cycle a write brings count to Depth, with no drop.
REQ-032 SHALL pop the oldest entry when readReq is high and count>0 (after REQ-028 ordering); readValid and the data appear the next cycle (latency 1).
REQ-033 SHALL make readReq with count==0 a no-op, leaving readValid low the next cycle.
REQ-034 SHALL accept reads in any state, without a full-buffer throughput penalty.
REQ-035 SHALL hold readPc, readCycle and readOpId at their last popped values when readValid is low.
REQ-036 SHALL keep count <= Depth at all times and wrap both pointers modulo Depth.

Reset
REQ-037 SHALL, with rst high at a rising edge, set state=IDLE, count=0, overflow=0, readValid=0, readPc/readCycle/readOpId=0, pointers=0, opId=0 and cycle counter=0.
REQ-038 SHALL let rst override start, stop, retires and readReq, discarding all stored entries, including mid-recording.
REQ-039 SHALL need no initialisation of the storage array; unwritten entries are never presented with readValid=1.

Verification
REQ-040 SHALL cover: Depth=4, Lanes=1, ring mode, start, then 6 retires with PC 0x100..0x114 step 4 -> count=4, overflow=1; four reads return PCs 0x108..0x114 with opId 2..5, then count=0.
REQ-041 SHALL cover: Depth=4, StopWhenFull=1, Lanes=2, three cycles of dual retires -> 4 entries stored, state=STOPPED after cycle 2, third cycle ignored, opId of the last entry = 3.
REQ-042 SHALL cover: RECORDING, retire PC 0x200 with hostIoValue=1 -> entry captured, state=STOPPED next cycle, later retires ignored.
REQ-043 SHALL cover: full ring buffer with readReq and one retire in the same cycle -> oldest entry returned, new entry stored, count unchanged, overflow stays 0.
REQ-044 SHALL cover: readReq on an empty buffer -> readValid=0 next cycle; rst mid-recording with count=3 -> count=0, state=IDLE next cycle.
REQ-045 SHALL cover: start and stop asserted together in STOPPED -> state=RECORDING, count=0, overflow=0.
